// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - first-word-fall-through FIFO on a memory array; optional FIFO_RAM_EMPTY_COUNT_EN adds OutEmptyCount
module fifo_ram #(
    parameter int Width     = 32,
    parameter int Buffering = 16,
    parameter int CntWidth  = $clog2(Buffering + 1)
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [Width-1:0]    InData,
    input  logic                InValid,
    output logic                InAccept,
    output logic [CntWidth-1:0] OutFullCount,
`ifdef FIFO_RAM_EMPTY_COUNT_EN
    output logic [CntWidth-1:0] OutEmptyCount,
`endif
    output logic [Width-1:0]    OutData,
    output logic                OutSend,
    input  logic                OutReady
);

    // A depth of 1 still needs a one-bit pointer to index the array.
    localparam int PtrWidth = (Buffering > 1) ? $clog2(Buffering) : 1;
    localparam logic [PtrWidth-1:0] LastPtr  = PtrWidth'(Buffering - 1);
    localparam logic [CntWidth-1:0] FullCnt  = CntWidth'(Buffering);

    logic [Width-1:0]    r_mem [Buffering];
    logic [PtrWidth-1:0] r_wr_ptr;
    logic [PtrWidth-1:0] r_rd_ptr;
    logic [CntWidth-1:0] r_count;

    logic                w_push;
    logic                w_pop;
    logic [PtrWidth-1:0] w_wr_ptr_next;
    logic [PtrWidth-1:0] w_rd_ptr_next;

    // Handshakes depend only on registered occupancy, so a full FIFO never passes through.
    always_comb begin
        InAccept      = (r_count != FullCnt);
        OutSend       = (r_count != '0);
        w_push        = InValid && InAccept;
        w_pop         = OutSend && OutReady;
        w_wr_ptr_next = (r_wr_ptr == LastPtr) ? '0 : r_wr_ptr + 1'b1;
        w_rd_ptr_next = (r_rd_ptr == LastPtr) ? '0 : r_rd_ptr + 1'b1;
    end

    assign OutFullCount = r_count;
    assign OutData      = r_mem[r_rd_ptr];
`ifdef FIFO_RAM_EMPTY_COUNT_EN
    assign OutEmptyCount = FullCnt - r_count;
`endif

    // Array write port; contents survive reset since OutSend masks stale data.
    always_ff @(posedge Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= InData;
        end
    end

    // Pointers wrap explicitly at Buffering-1 so non-power-of-two depths work.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_ram.sv
// tb/tb_fifo_ram.sv - scoreboard bench for fifo_ram at Width=8, Buffering=5
module tb_fifo_ram;

    localparam int W   = 8;
    localparam int B   = 5;
    localparam int CW  = $clog2(B + 1);

    logic          Clock;
    logic          Reset;
    logic [W-1:0]  InData;
    logic          InValid;
    logic          InAccept;
    logic [CW-1:0] OutFullCount;
`ifdef FIFO_RAM_EMPTY_COUNT_EN
    logic [CW-1:0] OutEmptyCount;
`endif
    logic [W-1:0]  OutData;
    logic          OutSend;
    logic          OutReady;

    int n_cmp = 0;
    int n_err = 0;
    logic [W-1:0] exp_q [$];

    fifo_ram #(.Width(W), .Buffering(B)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .InData       (InData),
        .InValid      (InValid),
        .InAccept     (InAccept),
        .OutFullCount (OutFullCount),
`ifdef FIFO_RAM_EMPTY_COUNT_EN
        .OutEmptyCount(OutEmptyCount),
`endif
        .OutData      (OutData),
        .OutSend      (OutSend),
        .OutReady     (OutReady)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every pop the DUT performs must match the scoreboard head.
    always @(negedge Clock) begin
        if (!Reset && OutSend && OutReady) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL pop_unexpected: got 0x%0h expected no output", OutData);
            end else begin
                chk("pop_data", {24'd0, OutData}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic check_state(input int cnt);
        chk("full_count", {{(32-CW){1'b0}}, OutFullCount}, cnt);
        chk("out_send", {31'd0, OutSend}, {31'd0, cnt != 0});
        chk("in_accept", {31'd0, InAccept}, {31'd0, cnt != B});
`ifdef FIFO_RAM_EMPTY_COUNT_EN
        chk("empty_count", {{(32-CW){1'b0}}, OutEmptyCount}, B - cnt);
`endif
    endtask

    // One clock: drive, check accept, record expected push, step, check count.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r,
                         input logic exp_acc, input int exp_cnt);
        InValid  = v;
        InData   = d;
        OutReady = r;
        chk("in_accept_pre", {31'd0, InAccept}, {31'd0, exp_acc});
        if (v && exp_acc) exp_q.push_back(d);
        @(posedge Clock);
        #1;
        check_state(exp_cnt);
    endtask

    initial begin
        Reset    = 1'b1;
        InValid  = 1'b0;
        InData   = '0;
        OutReady = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;

        // Idle after reset
        for (int i = 0; i < 3; i++) begin
            check_state(0);
            @(posedge Clock);
            #1;
        end

        // Three pushes, no bypass, fall-through after one edge
        InValid = 1'b1;
        InData  = 8'h11;
        chk("no_bypass", {31'd0, OutSend}, 32'd0);
        cycle(1'b1, 8'h11, 1'b0, 1'b1, 1);
        chk("fwft_data", {24'd0, OutData}, 32'h11);
        cycle(1'b1, 8'h22, 1'b0, 1'b1, 2);
        cycle(1'b1, 8'h33, 1'b0, 1'b1, 3);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b1, 1'b1, 2 - i);

        // Fill to full, drop the sixth, drain
        for (int i = 1; i <= 5; i++) cycle(1'b1, W'(i), 1'b0, 1'b1, i);
        cycle(1'b1, 8'h06, 1'b0, 1'b0, 5);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, i != 0, 4 - i);

        // Streaming across several pointer wraps
        for (int i = 0; i < 12; i++) cycle(1'b1, W'(8'h10 + i), 1'b1, 1'b1, 1);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 0);

        // Full with simultaneous push and pop
        for (int i = 1; i <= 5; i++) cycle(1'b1, W'(8'h40 + i), 1'b0, 1'b1, i);
        cycle(1'b1, 8'hAA, 1'b1, 1'b0, 4);
        cycle(1'b1, 8'hAA, 1'b0, 1'b1, 5);
        for (int i = 0; i < 5; i++) cycle(1'b0, 8'h00, 1'b1, i != 0, 4 - i);

        // Reset mid-operation dominates push and pop
        for (int i = 1; i <= 3; i++) cycle(1'b1, W'(8'h60 + i), 1'b0, 1'b1, i);
        exp_q.delete();
        Reset    = 1'b1;
        InValid  = 1'b1;
        InData   = 8'h99;
        OutReady = 1'b1;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        check_state(0);
        cycle(1'b1, 8'h77, 1'b0, 1'b1, 1);
        chk("head_after_reset", {24'd0, OutData}, 32'h77);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 0);

        InValid  = 1'b0;
        OutReady = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_ram.md
Name: fifo_ram

Overview:
- Parameterised first-word-fall-through FIFO built on a memory array, with valid/ready handshakes on both sides and an occupancy count output.
- Used to decouple fixed-latency producers, such as table read pipelines, from consumer control logic that may stall.
- Buffering is any positive integer, not only a power of two; a typical depth is the number of blocks on a path.

Parameters:
- Width, 32, data word width in bits.
- Buffering, 16, FIFO depth in entries (>=1, any integer).
- CntWidth, log2(Buffering+1), derived; width of the occupancy count. Not to be overridden.

Ports:
- Clock  in  1  single system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high reset.
- InData  in  Width  write data.
- InValid  in  1  producer presents InData this cycle.
- InAccept  out  1  FIFO can take a word this cycle.
- OutFullCount  out  CntWidth  number of entries currently held.
- OutData  out  Width  head-of-queue word; meaningful only while OutSend=1.
- OutSend  out  1  head word valid.
- OutReady  in  1  consumer takes the head word this cycle.

Behaviour:
- Push occurs when InValid & InAccept at a rising edge; InData is written at the write pointer.
- Pop occurs when OutSend & OutReady at a rising edge; the read pointer advances.
- InAccept = (OutFullCount != Buffering). It is combinational from registered state only and never depends on OutReady, so there is no pass-through when full.
- OutSend = (OutFullCount != 0). OutData = mem[read pointer] via combinational read of the array. This gives first-word fall-through: a word pushed at edge t appears on OutData with OutSend=1 after edge t, i.e. 1-cycle latency.
- No combinational bypass. InValid while empty does not assert OutSend in the same cycle.
- Simultaneous push and pop in one cycle (count strictly between 0 and Buffering): both pointers advance, count unchanged.
- Push and pop when count=0: only the push happens (OutSend is 0), count becomes 1.
- Pop at count=Buffering: count becomes Buffering-1. A push in that same cycle is ignored, since InAccept=0.
- Push while InAccept=0: word dropped, no state change.
- Pop while OutSend=0: no state change.
- Pointers count 0..Buffering-1 and wrap from Buffering-1 to 0; this must work for non-power-of-two depths.
- Count update is count + push - pop, saturating logic not needed because the guards above prevent overflow and underflow.
- Order is strict FIFO; data is never reordered or duplicated.
- Reset (including mid-operation): read pointer, write pointer and count go to 0 on the next edge, so OutSend=0, InAccept=1, OutFullCount=0.
  - Array contents are not cleared; OutData is don't-care while OutSend=0.
  - Reset dominates any simultaneous push or pop.
- Array may be inferred as distributed RAM or registers. It needs one write port and one asynchronous read port.

Optional Feature:
- Macro FIFO_RAM_EMPTY_COUNT_EN.
- When defined: adds output OutEmptyCount (CntWidth bits) = Buffering - OutFullCount. It is 0 when full and Buffering after reset, and is registered-state combinational like OutFullCount.
- When undefined: the port does not exist. All other behaviour is identical.

Test Plan (Width=8, Buffering=5):
- Reset, then idle: OutSend=0, InAccept=1, OutFullCount=0 every cycle.
- Push 0x11,0x22,0x33 on consecutive cycles with OutReady=0: OutSend=1 one cycle after the first push with OutData=0x11; OutFullCount steps 1,2,3.
- Push 0x01..0x05 with OutReady=0:
  - After the 5th push, InAccept=0 and OutFullCount=5.
  - A 6th push of 0x06 is dropped.
  - Draining then yields 0x01..0x05 only, then OutSend=0.
- Wrap-around: stream 12 words 0x10..0x1B with OutReady=1 continuously and InValid=1. The output sequence is 0x10..0x1B in order with no loss, and count stays <=1.
- Full with simultaneous push and pop: at count=5 assert InValid (0xAA) and OutReady. The head is popped, 0xAA is not accepted, and count becomes 4. Next cycle push 0xAA is accepted, and 0xAA is the last word drained.
- Assert Reset with count=3: next cycle count=0, OutSend=0, InAccept=1. Subsequent push 0x77 is the first word out. With FIFO_RAM_EMPTY_COUNT_EN, OutEmptyCount=5 after reset and 4 after that push.
